// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and widths for the reset sequencer.
package rst_seq_pkg;
  typedef enum logic [2:0] {
    IDLE_RST = 3'd0,
    SYNC     = 3'd1,
    HOLD     = 3'd2,
    REL_CORE = 3'd3,
    RUN      = 3'd4,
    DONE     = 3'd5,
    TOUT     = 3'd6
  } state_t;
  localparam int CNT_W = 32;
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction
endpackage

// File: rtl/rst_seq_sync.sv
// rst_sync: async-assert, sync-deassert reset synchronizer (active-low in and out).
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic sync_reset
);
  localparam int N = (STAGES < 2) ? 2 : STAGES;
  logic [N-1:0] s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) s <= '0;
    else s <= {s[N-2:0], 1'b1};
  assign sync_reset = s[N-1];
endmodule

// File: rtl/rst_seq.sv
// rst_seq: staged release of core/search resets with run watchdog and cycle counter.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int WDOG_CYCLES    = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_rst_req,
  input  logic             core_done,
  output logic             core_rst_n,
  output logic             search_rst_n,
  output logic             run,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       state
);
  localparam int HC = at_least_one(HOLD_CYCLES);
  localparam int SC = at_least_one(STAGGER_CYCLES);
  localparam int TW = $clog2((HC > SC) ? HC : SC) + 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
  state_t st, nxt;
  logic [TW-1:0] tmr;
  logic sync_reset, sw, wdog_hit;
  rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sync_reset(sync_reset)
  );
  assign sw = sw_rst_req && st != IDLE_RST && st != SYNC;
  assign wdog_hit = cycle_cnt == WDOG_LAST;
  always_comb begin
    nxt = st;
    case (st)
      IDLE_RST: nxt = SYNC;
      SYNC:     nxt = HOLD;
      HOLD:     nxt = (tmr == '0) ? REL_CORE : HOLD;
      REL_CORE: nxt = (tmr == '0) ? RUN : REL_CORE;
      RUN:      nxt = core_done ? DONE : wdog_hit ? TOUT : RUN;
      default:  nxt = st;
    endcase
    if (sw) nxt = HOLD;
  end
  // the whole FSM sits under the synchronized reset, so it leaves IDLE_RST on the first clean edge
  always_ff @(posedge clk or negedge sync_reset)
    if (!sync_reset) begin
      st           <= IDLE_RST;
      tmr          <= '0;
      core_rst_n   <= 1'b0;
      search_rst_n <= 1'b0;
      run          <= 1'b0;
      timeout      <= 1'b0;
      cycle_cnt    <= '0;
    end else begin
      st           <= nxt;
      tmr          <= (nxt == HOLD && (st != HOLD || sw)) ? TW'(HC - 1) :
                      (nxt == REL_CORE && st != REL_CORE) ? TW'(SC - 1) :
                      (tmr == '0) ? tmr : tmr - TW'(1);
      core_rst_n   <= nxt inside {REL_CORE, RUN, DONE, TOUT};
      search_rst_n <= nxt inside {RUN, DONE};
      run          <= nxt == RUN;
      timeout      <= nxt == TOUT;
      cycle_cnt    <= sw ? '0 :
                      (st == RUN && nxt != TOUT && ~&cycle_cnt) ? cycle_cnt + CNT_W'(1) : cycle_cnt;
    end
  assign state = st;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed checks of the reset sequencer (default watchdog and a 50-cycle watchdog instance).
`timescale 1ns/1ps
module tb_rst_seq;
  logic clk = 1'b0, reset = 1'b0, sw_rst_req = 1'b0, core_done = 1'b0, core_done_w = 1'b0;
  logic core_rst_n, search_rst_n, run, timeout;
  logic w_core_rst_n, w_search_rst_n, w_run, w_timeout;
  logic [31:0] cycle_cnt, w_cycle_cnt;
  logic [2:0] state, w_state;
  int n_cmp = 0, n_bad = 0;
  localparam logic [2:0] S_IDLE = 3'd0, S_HOLD = 3'd2, S_REL = 3'd3, S_RUN = 3'd4, S_DONE = 3'd5, S_TOUT = 3'd6;

  always #5 clk = ~clk;

  rst_seq dut (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .core_done(core_done),
    .core_rst_n(core_rst_n), .search_rst_n(search_rst_n), .run(run),
    .timeout(timeout), .cycle_cnt(cycle_cnt), .state(state)
  );

  rst_seq #(.WDOG_CYCLES(50)) dut_w (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .core_done(core_done_w),
    .core_rst_n(w_core_rst_n), .search_rst_n(w_search_rst_n), .run(w_run),
    .timeout(w_timeout), .cycle_cnt(w_cycle_cnt), .state(w_state)
  );

  task automatic test_reset;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (state !== S_IDLE || core_rst_n !== 1'b0 || search_rst_n !== 1'b0 || run !== 1'b0 || timeout !== 1'b0 || cycle_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_dut: got st=%0d core=%b search=%b run=%b tout=%b cnt=%0d, want all 0", state, core_rst_n, search_rst_n, run, timeout, cycle_cnt);
    end
    n_cmp++;
    if (w_state !== S_IDLE || w_core_rst_n !== 1'b0 || w_search_rst_n !== 1'b0 || w_run !== 1'b0 || w_timeout !== 1'b0 || w_cycle_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_dut_w: got st=%0d core=%b search=%b run=%b tout=%b cnt=%0d, want all 0", w_state, w_core_rst_n, w_search_rst_n, w_run, w_timeout, w_cycle_cnt);
    end
  endtask

  task automatic test_powerup;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i <= 23; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (core_rst_n !== (i >= 19) || search_rst_n !== (i >= 23) || run !== (i >= 23)) begin
        n_bad++;
        $display("FAIL powerup_c%0d: got core=%b search=%b run=%b, want core=%b search=%b run=%b", i, core_rst_n, search_rst_n, run, i >= 19, i >= 23, i >= 23);
      end
    end
    n_cmp++;
    if (state !== S_RUN || cycle_cnt !== 32'd0 || w_state !== S_RUN) begin
      n_bad++;
      $display("FAIL powerup_run: got st=%0d cnt=%0d w_st=%0d, want st=4 cnt=0 w_st=4", state, cycle_cnt, w_state);
    end
  endtask

  task automatic test_watchdog;
    repeat (49) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (w_state !== S_RUN || w_cycle_cnt !== 32'd49) begin
      n_bad++;
      $display("FAIL wdog_pre: got st=%0d cnt=%0d, want st=4 cnt=49", w_state, w_cycle_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (w_state !== S_TOUT || w_timeout !== 1'b1 || w_search_rst_n !== 1'b0 || w_core_rst_n !== 1'b1 || w_run !== 1'b0 || w_cycle_cnt !== 32'd49) begin
      n_bad++;
      $display("FAIL wdog_tout: got st=%0d tout=%b search=%b core=%b run=%b cnt=%0d, want st=6 tout=1 search=0 core=1 run=0 cnt=49", w_state, w_timeout, w_search_rst_n, w_core_rst_n, w_run, w_cycle_cnt);
    end
  endtask

  task automatic test_done;
    repeat (49) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (state !== S_RUN || cycle_cnt !== 32'd99) begin
      n_bad++;
      $display("FAIL done_pre: got st=%0d cnt=%0d, want st=4 cnt=99", state, cycle_cnt);
    end
    core_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_done = 1'b0;
    n_cmp++;
    if (state !== S_DONE || cycle_cnt !== 32'd100 || run !== 1'b0 || timeout !== 1'b0 || core_rst_n !== 1'b1 || search_rst_n !== 1'b1) begin
      n_bad++;
      $display("FAIL done: got st=%0d cnt=%0d run=%b tout=%b core=%b search=%b, want st=5 cnt=100 run=0 tout=0 core=1 search=1", state, cycle_cnt, run, timeout, core_rst_n, search_rst_n);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state !== S_DONE || cycle_cnt !== 32'd100 || w_state !== S_TOUT || w_cycle_cnt !== 32'd49 || w_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL terminal: got st=%0d cnt=%0d w_st=%0d w_cnt=%0d w_tout=%b, want 5 100 6 49 1", state, cycle_cnt, w_state, w_cycle_cnt, w_timeout);
    end
  endtask

  task automatic test_sw_tout;
    sw_rst_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_rst_req = 1'b0;
    n_cmp++;
    if (w_state !== S_HOLD || w_core_rst_n !== 1'b0 || w_search_rst_n !== 1'b0 || w_timeout !== 1'b0 || w_cycle_cnt !== 32'd0 || w_run !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_tout: got st=%0d core=%b search=%b tout=%b cnt=%0d run=%b, want st=2 all 0", w_state, w_core_rst_n, w_search_rst_n, w_timeout, w_cycle_cnt, w_run);
    end
    n_cmp++;
    if (state !== S_HOLD || core_rst_n !== 1'b0 || search_rst_n !== 1'b0 || cycle_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL sw_done: got st=%0d core=%b search=%b cnt=%0d, want st=2 core=0 search=0 cnt=0", state, core_rst_n, search_rst_n, cycle_cnt);
    end
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (w_core_rst_n !== (j >= 16) || w_search_rst_n !== (j >= 20) || w_run !== (j >= 20)) begin
        n_bad++;
        $display("FAIL sw_tout_seq_c%0d: got core=%b search=%b run=%b, want core=%b search=%b run=%b", j, w_core_rst_n, w_search_rst_n, w_run, j >= 16, j >= 20, j >= 20);
      end
    end
  endtask

  task automatic test_collision;
    repeat (49) @(posedge clk);
    @(negedge clk);
    core_done_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_done_w = 1'b0;
    n_cmp++;
    if (w_state !== S_DONE || w_timeout !== 1'b0 || w_cycle_cnt !== 32'd50 || w_search_rst_n !== 1'b1) begin
      n_bad++;
      $display("FAIL collision: got st=%0d tout=%b cnt=%0d search=%b, want st=5 tout=0 cnt=50 search=1", w_state, w_timeout, w_cycle_cnt, w_search_rst_n);
    end
  endtask

  task automatic test_sw_rel_core;
    sw_rst_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_rst_req = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (state !== S_REL || core_rst_n !== 1'b1 || search_rst_n !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_core_reached: got st=%0d core=%b search=%b, want st=3 core=1 search=0", state, core_rst_n, search_rst_n);
    end
    sw_rst_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_rst_req = 1'b0;
    n_cmp++;
    if (state !== S_HOLD || core_rst_n !== 1'b0 || search_rst_n !== 1'b0 || cycle_cnt !== 32'd0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_rel_core: got st=%0d core=%b search=%b cnt=%0d tout=%b, want st=2 all 0", state, core_rst_n, search_rst_n, cycle_cnt, timeout);
    end
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (core_rst_n !== (j >= 16) || search_rst_n !== (j >= 20) || run !== (j >= 20)) begin
        n_bad++;
        $display("FAIL sw_rel_seq_c%0d: got core=%b search=%b run=%b, want core=%b search=%b run=%b", j, core_rst_n, search_rst_n, run, j >= 16, j >= 20, j >= 20);
      end
    end
  endtask

  task automatic test_midrun_reset;
    time t0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (state !== S_RUN || cycle_cnt !== 32'd10) begin
      n_bad++;
      $display("FAIL midrun_pre: got st=%0d cnt=%0d, want st=4 cnt=10", state, cycle_cnt);
    end
    @(posedge clk);
    #3;
    t0 = $time;
    reset = 1'b0;
    fork
      wait (state === S_IDLE && core_rst_n === 1'b0 && search_rst_n === 1'b0 && run === 1'b0 && timeout === 1'b0 && cycle_cnt === 32'd0);
      #4;
    join_any
    disable fork;
    n_cmp++;
    if ($time != t0 || state !== S_IDLE || core_rst_n !== 1'b0 || search_rst_n !== 1'b0 || run !== 1'b0 || cycle_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset: got t=%0t st=%0d core=%b search=%b run=%b cnt=%0d, want t=%0t all 0", $time, state, core_rst_n, search_rst_n, run, cycle_cnt, t0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sw_rst_req = 1'b1;
    for (int i = 0; i <= 23; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 3) sw_rst_req = 1'b0;
      n_cmp++;
      if (core_rst_n !== (i >= 19) || search_rst_n !== (i >= 23) || run !== (i >= 23)) begin
        n_bad++;
        $display("FAIL reseq_c%0d: got core=%b search=%b run=%b, want core=%b search=%b run=%b", i, core_rst_n, search_rst_n, run, i >= 19, i >= 23, i >= 23);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running at %0t, want finished", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_powerup();
    test_watchdog();
    test_done();
    test_sw_tout();
    test_collision();
    test_sw_rel_core();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
